// File: rtl/rv32_alu_arbiter_if.sv
// Requester and ALU-side bundle for rv32_alu_arbiter.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever drives requests, acks and ALU results into it.
interface rv32_alu_arbiter_if;
    // requester side
    logic [1:0]  i_req_valid;
    logic [63:0] i_req_op_one;
    logic [63:0] i_req_op_two;
    logic [3:0]  i_req_sel;
    logic [1:0]  o_req_ready;
    logic [1:0]  o_rsp_valid;
    logic [31:0] o_rsp_result;
    logic        o_rsp_carry;
    logic        o_rsp_error;
    logic [1:0]  i_rsp_ack;
    // ALU side
    logic [31:0] o_alu_operand_one;
    logic [31:0] o_alu_operand_two;
    logic [1:0]  o_alu_sel;
    logic        o_alu_stall_reset;
    logic [31:0] i_alu_result;
    logic        i_alu_carry_out;
    logic        i_alu_data_valid;

    modport slave (
        input  i_req_valid, i_req_op_one, i_req_op_two, i_req_sel, i_rsp_ack,
        input  i_alu_result, i_alu_carry_out, i_alu_data_valid,
        output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_carry, o_rsp_error,
        output o_alu_operand_one, o_alu_operand_two, o_alu_sel, o_alu_stall_reset
    );

    modport master (
        output i_req_valid, i_req_op_one, i_req_op_two, i_req_sel, i_rsp_ack,
        output i_alu_result, i_alu_carry_out, i_alu_data_valid,
        input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_carry, o_rsp_error,
        input  o_alu_operand_one, o_alu_operand_two, o_alu_sel, o_alu_stall_reset
    );
endinterface

// File: rtl/rv32_alu_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared multicycle
// ALU. One operation is in flight at a time: IDLE picks a winner, BUSY runs
// the ALU with held operands until data valid or a bounded timeout, RESP
// holds the response for the winner until it acknowledges.
module rv32_alu_arbiter #(
    parameter int MAX_ATTEMPTS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    rv32_alu_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_ATTEMPTS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // one-hot decode of a requester index
    function automatic logic [1:0] f_onehot(input logic id);
        f_onehot = id ? 2'b10 : 2'b01;
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic              r_grant_id;
    logic              r_rr_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_op_one;
    logic [31:0]       r_op_two;
    logic [1:0]        r_sel;
    logic [31:0]       r_result;
    logic              r_carry;
    logic              r_error;

    logic              w_any;
    logic              w_winner;
    logic              w_accept;
    logic              w_last;

    // winner selection: round-robin pointer breaks ties, a lone requester wins outright
    always_comb begin
        w_any    = |bus.i_req_valid;
        w_winner = 1'b0;
        if (bus.i_req_valid == 2'b11) begin
            w_winner = r_rr_ptr;
        end else if (bus.i_req_valid[1]) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
        // ready is offered to the winner whenever anyone is valid, so valid&ready == w_any
        w_accept = (r_state == S_IDLE) && w_any;
        w_last   = (r_cnt == LAST_CNT);
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state logic; data valid is tested first so it beats the final count
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_BUSY;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus.i_alu_data_valid || w_last) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_BUSY;
                end
            end
            S_RESP: begin
                if (bus.i_rsp_ack[r_grant_id]) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // holding registers, grant bookkeeping and timeout counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_grant_id <= 1'b0;
            r_rr_ptr   <= 1'b0;
            r_cnt      <= '0;
            r_op_one   <= 32'd0;
            r_op_two   <= 32'd0;
            r_sel      <= 2'd0;
            r_result   <= 32'd0;
            r_carry    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= ~w_winner;
                        r_cnt      <= '0;
                        r_op_one   <= w_winner ? bus.i_req_op_one[63:32] : bus.i_req_op_one[31:0];
                        r_op_two   <= w_winner ? bus.i_req_op_two[63:32] : bus.i_req_op_two[31:0];
                        r_sel      <= w_winner ? bus.i_req_sel[3:2]      : bus.i_req_sel[1:0];
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (bus.i_alu_data_valid) begin
                        r_result <= bus.i_alu_result;
                        r_carry  <= bus.i_alu_carry_out;
                        r_error  <= 1'b0;
                    end else if (w_last) begin
                        r_result <= 32'd0;
                        r_carry  <= 1'b0;
                        r_error  <= 1'b1;
                    end
                end
                S_RESP: begin
                    // response is held until the granted requester acks
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // outputs: ready is the only combinational path from inputs; the rest decode registers
    always_comb begin
        bus.o_req_ready       = 2'b00;
        bus.o_rsp_valid       = 2'b00;
        bus.o_alu_stall_reset = 1'b0;
        if ((r_state == S_IDLE) && w_any) begin
            bus.o_req_ready = f_onehot(w_winner);
        end else begin
            bus.o_req_ready = 2'b00;
        end
        if (r_state == S_RESP) begin
            bus.o_rsp_valid = f_onehot(r_grant_id);
        end else begin
            bus.o_rsp_valid = 2'b00;
        end
        if (r_state == S_BUSY) begin
            bus.o_alu_stall_reset = 1'b1;
        end else begin
            bus.o_alu_stall_reset = 1'b0;
        end
        bus.o_rsp_result      = r_result;
        bus.o_rsp_carry       = r_carry;
        bus.o_rsp_error       = r_error;
        bus.o_alu_operand_one = r_op_one;
        bus.o_alu_operand_two = r_op_two;
        bus.o_alu_sel         = r_sel;
    end

endmodule
